// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order commit,
// with mispredict rollback of younger entries and full flush on an excepting commit.
module rob_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AREG_W = 5,
    parameter int unsigned PC_W   = 32,
    localparam int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [AREG_W-1:0] alloc_areg,
    input  logic [PC_W-1:0]   alloc_pc,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_exc,
    input  logic              rb_valid,
    input  logic [TAG_W-1:0]  rb_tag,
    output logic              cm_valid,
    input  logic              cm_ready,
    output logic [TAG_W-1:0]  cm_tag,
    output logic              cm_has_dest,
    output logic [AREG_W-1:0] cm_areg,
    output logic [DATA_W-1:0] cm_data,
    output logic [PC_W-1:0]   cm_pc,
    output logic              cm_exc,
    output logic              exc_flush,
    output logic [PC_W-1:0]   exc_pc,
    output logic [TAG_W:0]    count,
    output logic              empty
);

    localparam int unsigned PTR_W = TAG_W + 1;

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
    logic              exc_flush_q, exc_flush_d;
    logic [PC_W-1:0]   exc_pc_q, exc_pc_d;

    logic [DEPTH-1:0]  exc_q, has_dest_q;
    logic [AREG_W-1:0] areg_q [DEPTH];
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [TAG_W-1:0]  head_idx, tail_idx, rb_off;
    logic              full, alloc_fire, cm_fire, exc_commit, wb_hit;

    assign head_idx   = head_q[TAG_W-1:0];
    assign tail_idx   = tail_q[TAG_W-1:0];
    assign count      = tail_q - head_q;
    assign full       = (count == PTR_W'(DEPTH));
    assign empty      = (count == '0);

    assign alloc_ready = !full && !rb_valid && !exc_flush_q;
    assign alloc_tag   = tail_idx;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign wb_hit      = wb_valid && valid_q[wb_tag];

    assign cm_valid    = valid_q[head_idx] && done_q[head_idx];
    assign cm_tag      = head_idx;
    assign cm_has_dest = has_dest_q[head_idx];
    assign cm_areg     = areg_q[head_idx];
    assign cm_data     = data_q[head_idx];
    assign cm_pc       = pc_q[head_idx];
    assign cm_exc      = exc_q[head_idx];
    assign cm_fire     = cm_valid && cm_ready;
    assign exc_commit  = cm_fire && cm_exc;

    assign exc_flush   = exc_flush_q;
    assign exc_pc      = exc_pc_q;

    // Age of rb_tag relative to head; entries older-or-equal survive.
    assign rb_off = TAG_W'(rb_tag - head_idx);

    // Later statements override earlier ones, giving exception > rollback > alloc.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        done_d      = done_q;
        exc_flush_d = 1'b0;
        exc_pc_d    = exc_pc_q;

        if (wb_hit) begin
            done_d[wb_tag] = 1'b1;
        end
        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (cm_fire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end
        if (rb_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (TAG_W'(TAG_W'(i) - head_idx) > rb_off) begin
                    valid_d[i] = 1'b0;
                end
            end
            tail_d = head_q + PTR_W'(rb_off) + PTR_W'(1);
        end
        if (exc_commit) begin
            valid_d     = '0;
            tail_d      = head_q + PTR_W'(1);
            exc_flush_d = 1'b1;
            exc_pc_d    = pc_q[head_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            exc_flush_q <= 1'b0;
            exc_pc_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            exc_flush_q <= exc_flush_d;
            exc_pc_q    <= exc_pc_d;
        end
    end

    // Payload storage needs no reset; valid/done gate every use of it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_idx] <= alloc_has_dest;
            areg_q[tail_idx]     <= alloc_areg;
            pc_q[tail_idx]       <= alloc_pc;
        end
        if (wb_hit) begin
            data_q[wb_tag] <= wb_data;
            exc_q[wb_tag]  <= wb_exc;
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Self-checking bench for rob_queue: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_rob_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alloc_valid = 1'b0, alloc_ready, alloc_has_dest = 1'b0;
    logic [4:0]  alloc_areg = '0;
    logic [31:0] alloc_pc = '0;
    logic [3:0]  alloc_tag;
    logic        wb_valid = 1'b0, wb_exc = 1'b0;
    logic [3:0]  wb_tag = '0;
    logic [31:0] wb_data = '0;
    logic        rb_valid = 1'b0;
    logic [3:0]  rb_tag = '0;
    logic        cm_valid, cm_ready = 1'b0;
    logic [3:0]  cm_tag;
    logic        cm_has_dest, cm_exc, exc_flush, empty;
    logic [4:0]  cm_areg;
    logic [31:0] cm_data, cm_pc, exc_pc;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_fail = 0;

    rob_queue dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_areg(alloc_areg),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
        .rb_valid(rb_valid), .rb_tag(rb_tag),
        .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_tag(cm_tag),
        .cm_has_dest(cm_has_dest), .cm_areg(cm_areg), .cm_data(cm_data),
        .cm_pc(cm_pc), .cm_exc(cm_exc),
        .exc_flush(exc_flush), .exc_pc(exc_pc),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: live instructions in program order.
    typedef struct {
        logic [3:0]  tag;
        logic        hd;
        logic [4:0]  areg;
        logic [31:0] pc;
        logic        done;
        logic [31:0] data;
        logic        exc;
    } ent_t;

    ent_t        mq[$];
    int          m_next = 0;
    bit          m_flush = 0;
    logic [31:0] m_exc_pc = '0;

    task automatic idle_inputs();
        alloc_valid = 0; alloc_has_dest = 0; alloc_areg = '0; alloc_pc = '0;
        wb_valid = 0; wb_tag = '0; wb_data = '0; wb_exc = 0;
        rb_valid = 0; rb_tag = '0; cm_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        mq.delete(); m_next = 0; m_flush = 0; m_exc_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic tick();
        bit   af, cf;
        ent_t he, ne;
        int   keep, k;
        af = alloc_valid && (mq.size() < DEPTH) && !rb_valid && !m_flush;
        cf = cm_ready && (mq.size() > 0) && mq[0].done;
        keep = -1;
        if (cf) he = mq[0];
        if (rb_valid) foreach (mq[i]) if (mq[i].tag == rb_tag) keep = i + 1;
        if (wb_valid) foreach (mq[i]) if (mq[i].tag == wb_tag) begin
            mq[i].done = 1; mq[i].data = wb_data; mq[i].exc = wb_exc;
        end
        m_flush = 0;
        if (af) begin
            ne.tag = 4'(m_next); ne.hd = alloc_has_dest; ne.areg = alloc_areg;
            ne.pc = alloc_pc; ne.done = 0; ne.data = '0; ne.exc = 0;
            mq.push_back(ne);
            m_next = (m_next + 1) % DEPTH;
        end
        if (cf) void'(mq.pop_front());
        if (keep >= 0) begin
            k = cf ? keep - 1 : keep;
            while (mq.size() > k) void'(mq.pop_back());
            m_next = (int'(rb_tag) + 1) % DEPTH;
        end
        if (cf && he.exc) begin
            mq.delete();
            m_next = (int'(he.tag) + 1) % DEPTH;
            m_flush = 1;
            m_exc_pc = he.pc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset alloc_ready got=%b exp=1", alloc_ready); end
        n_cmp++; if (alloc_tag !== 4'd0) begin n_fail++; $display("FAIL reset alloc_tag got=%0d exp=0", alloc_tag); end
        n_cmp++; if (cm_valid !== 1'b0) begin n_fail++; $display("FAIL reset cm_valid got=%b exp=0", cm_valid); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset empty got=%b exp=1", empty); end
        n_cmp++; if (exc_flush !== 1'b0) begin n_fail++; $display("FAIL reset exc_flush got=%b exp=0", exc_flush); end
        n_cmp++; if (exc_pc !== 32'd0) begin n_fail++; $display("FAIL reset exc_pc got=%h exp=0", exc_pc); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1; alloc_pc = 32'h1000 + 32'(i * 4); alloc_areg = 5'(i);
            #1;
            n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 4'(i)) begin
                n_fail++; $display("FAIL fill alloc i=%0d got rdy=%b tag=%0d exp rdy=1 tag=%0d", i, alloc_ready, alloc_tag, i);
            end
            tick();
        end
        alloc_valid = 0;
        #1;
        n_cmp++; if (alloc_ready !== 1'b0 || count !== 5'd16) begin
            n_fail++; $display("FAIL full got rdy=%b count=%0d exp rdy=0 count=16", alloc_ready, count);
        end
        cm_ready = 1;
        for (int k = 0; k < DEPTH; k++) begin
            wb_valid = 1; wb_tag = 4'(DEPTH - 1 - k); wb_data = $urandom;
            #1;
            n_cmp++; if (cm_valid !== 1'b0) begin n_fail++; $display("FAIL drain early cm_valid k=%0d got=%b exp=0", k, cm_valid); end
            tick();
        end
        wb_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_cmp++; if (cm_valid !== 1'b1 || cm_tag !== 4'(i)) begin
                n_fail++; $display("FAIL drain order i=%0d got v=%b tag=%0d exp v=1 tag=%0d", i, cm_valid, cm_tag, i);
            end
            tick();
        end
        #1;
        n_cmp++; if (empty !== 1'b1 || cm_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain end got empty=%b cm_valid=%b exp empty=1 cm_valid=0", empty, cm_valid);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int first;
        first = m_next;
        cm_ready = 1;
        for (int k = 0; k < 48; k++) begin
            alloc_valid = (k < 45);
            alloc_pc = 32'h2000 + 32'(k * 4);
            wb_valid = (k >= 1 && k <= 45);
            wb_tag = 4'((first + k - 1) % DEPTH);
            wb_data = $urandom;
            #1;
            if (k >= 2 && k < 45) begin
                n_cmp++; if (count !== 5'd2 || cm_valid !== 1'b1 || cm_tag !== 4'((first + k - 2) % DEPTH)) begin
                    n_fail++; $display("FAIL b2b k=%0d got count=%0d v=%b tag=%0d exp count=2 v=1 tag=%0d",
                                       k, count, cm_valid, cm_tag, (first + k - 2) % DEPTH);
                end
            end
            tick();
        end
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b end empty got=%b exp=1", empty); end
        idle_inputs();
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1; alloc_pc = 32'h3000 + 32'(i * 4);
            tick();
        end
        alloc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1; wb_tag = 4'(i); wb_data = 32'(i + 100);
            tick();
        end
        wb_valid = 0;
        rb_valid = 1; rb_tag = 4'd3;
        #1;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL rb ready during rollback got=%b exp=0", alloc_ready); end
        tick();
        rb_valid = 0;
        #1;
        n_cmp++; if (count !== 5'd4 || alloc_tag !== 4'd4) begin
            n_fail++; $display("FAIL rb after got count=%0d tag=%0d exp count=4 tag=4", count, alloc_tag);
        end
        wb_valid = 1; wb_tag = 4'd6; wb_data = 32'hdead;
        tick();
        wb_valid = 0;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1; alloc_pc = 32'h3100 + 32'(i * 4);
            tick();
        end
        alloc_valid = 0;
        for (int i = 3; i < 6; i++) begin
            wb_valid = 1; wb_tag = 4'(i); wb_data = 32'(i + 100);
            tick();
        end
        wb_valid = 0;
        cm_ready = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (cm_valid !== 1'b1 || cm_tag !== 4'(i)) begin
                n_fail++; $display("FAIL rb commit i=%0d got v=%b tag=%0d exp v=1 tag=%0d", i, cm_valid, cm_tag, i);
            end
            tick();
        end
        #1;
        n_cmp++; if (cm_valid !== 1'b0 || count !== 5'd1) begin
            n_fail++; $display("FAIL rb stale wb got cm_valid=%b count=%0d exp cm_valid=0 count=1", cm_valid, count);
        end
        wb_valid = 1; wb_tag = 4'd6; wb_data = 32'h6;
        tick();
        wb_valid = 0;
        tick();
        idle_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1; alloc_pc = (i == 1) ? 32'h100 : 32'h4000 + 32'(i * 4);
            tick();
        end
        alloc_valid = 0;
        wb_valid = 1; wb_tag = 4'd0; wb_data = 32'h11; wb_exc = 0;
        tick();
        wb_tag = 4'd1; wb_data = 32'h22; wb_exc = 1;
        tick();
        wb_valid = 0; wb_exc = 0;
        cm_ready = 1;
        #1;
        n_cmp++; if (cm_valid !== 1'b1 || cm_tag !== 4'd0 || cm_exc !== 1'b0) begin
            n_fail++; $display("FAIL exc c0 got v=%b tag=%0d exc=%b exp v=1 tag=0 exc=0", cm_valid, cm_tag, cm_exc);
        end
        tick();
        #1;
        n_cmp++; if (cm_valid !== 1'b1 || cm_tag !== 4'd1 || cm_exc !== 1'b1 || cm_pc !== 32'h100) begin
            n_fail++; $display("FAIL exc c1 got v=%b tag=%0d exc=%b pc=%h exp v=1 tag=1 exc=1 pc=100", cm_valid, cm_tag, cm_exc, cm_pc);
        end
        tick();
        cm_ready = 0;
        #1;
        n_cmp++; if (exc_flush !== 1'b1 || exc_pc !== 32'h100 || count !== 5'd0 || alloc_ready !== 1'b0) begin
            n_fail++; $display("FAIL exc flush got fl=%b pc=%h count=%0d rdy=%b exp fl=1 pc=100 count=0 rdy=0",
                               exc_flush, exc_pc, count, alloc_ready);
        end
        tick();
        #1;
        n_cmp++; if (exc_flush !== 1'b0 || alloc_ready !== 1'b1 || exc_pc !== 32'h100 || alloc_tag !== 4'd2) begin
            n_fail++; $display("FAIL exc after got fl=%b rdy=%b pc=%h tag=%0d exp fl=0 rdy=1 pc=100 tag=2",
                               exc_flush, alloc_ready, exc_pc, alloc_tag);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit e_rdy, e_cv;
        int idx;
        for (int c = 0; c < 2000; c++) begin
            alloc_valid = ($urandom_range(0, 99) < 65);
            alloc_has_dest = 1'($urandom); alloc_areg = 5'($urandom); alloc_pc = $urandom;
            wb_valid = ($urandom_range(0, 99) < 60);
            if (mq.size() > 0 && $urandom_range(0, 99) < 80) begin
                idx = $urandom_range(0, mq.size() - 1);
                wb_tag = mq[idx].tag;
            end else begin
                wb_tag = 4'($urandom);
            end
            wb_data = $urandom; wb_exc = ($urandom_range(0, 99) < 3);
            cm_ready = ($urandom_range(0, 99) < 70);
            rb_valid = 0;
            if (mq.size() > 0 && $urandom_range(0, 99) < 5) begin
                idx = $urandom_range(0, mq.size() - 1);
                rb_valid = 1; rb_tag = mq[idx].tag;
            end
            #1;
            e_rdy = (mq.size() < DEPTH) && !rb_valid && !m_flush;
            e_cv  = (mq.size() > 0) && mq[0].done;
            n_cmp++; if (alloc_ready !== e_rdy) begin n_fail++; $display("FAIL rand alloc_ready c=%0d got=%b exp=%b", c, alloc_ready, e_rdy); end
            n_cmp++; if (alloc_tag !== 4'(m_next)) begin n_fail++; $display("FAIL rand alloc_tag c=%0d got=%0d exp=%0d", c, alloc_tag, m_next); end
            n_cmp++; if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL rand count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
            n_cmp++; if (empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rand empty c=%0d got=%b exp=%b", c, empty, mq.size() == 0); end
            n_cmp++; if (cm_valid !== e_cv) begin n_fail++; $display("FAIL rand cm_valid c=%0d got=%b exp=%b", c, cm_valid, e_cv); end
            n_cmp++; if (exc_flush !== m_flush || exc_pc !== m_exc_pc) begin
                n_fail++; $display("FAIL rand exc c=%0d got fl=%b pc=%h exp fl=%b pc=%h", c, exc_flush, exc_pc, m_flush, m_exc_pc);
            end
            if (e_cv) begin
                n_cmp++;
                if (cm_tag !== mq[0].tag || cm_has_dest !== mq[0].hd || cm_areg !== mq[0].areg ||
                    cm_data !== mq[0].data || cm_pc !== mq[0].pc || cm_exc !== mq[0].exc) begin
                    n_fail++; $display("FAIL rand fields c=%0d got tag=%0d d=%h pc=%h exc=%b exp tag=%0d d=%h pc=%h exc=%b",
                                       c, cm_tag, cm_data, cm_pc, cm_exc, mq[0].tag, mq[0].data, mq[0].pc, mq[0].exc);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_stall_reset();
        do_reset();
        alloc_valid = 1; alloc_has_dest = 1; alloc_areg = 5'd9; alloc_pc = 32'h5000;
        tick();
        idle_inputs();
        wb_valid = 1; wb_tag = 4'd0; wb_data = 32'hcafe_f00d;
        tick();
        wb_valid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (cm_valid !== 1'b1 || cm_tag !== 4'd0 || cm_data !== 32'hcafe_f00d ||
                         cm_pc !== 32'h5000 || cm_areg !== 5'd9 || cm_has_dest !== 1'b1) begin
                n_fail++; $display("FAIL stall i=%0d got v=%b tag=%0d d=%h pc=%h areg=%0d exp v=1 tag=0 d=cafef00d pc=5000 areg=9",
                                   i, cm_valid, cm_tag, cm_data, cm_pc, cm_areg);
            end
            tick();
        end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (cm_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL async reset got v=%b count=%0d empty=%b exp v=0 count=0 empty=1", cm_valid, count, empty);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_rollback();
        test_exception();
        test_random();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_queue.md
# rob_queue

Parametrised reorder buffer for the out-of-order core. It allocates one entry per cycle in program order at dispatch and accepts one out-of-order writeback per cycle from the execution units. It retires completed entries in order, one per cycle, to the architectural register file. It supports branch-mispredict rollback of younger entries and full flush on a committed exception.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, ≥ 4
- DATA_W, 32, result data width
- AREG_W, 5, architectural register index width
- PC_W, 32, instruction address width
- TAG_W, $clog2(DEPTH), entry tag width (derived, not overridden)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- alloc_valid  input  1  dispatch requests an entry
- alloc_ready  output  1  entry available this cycle
- alloc_has_dest  input  1  instruction writes a register
- alloc_areg  input  AREG_W  destination register
- alloc_pc  input  PC_W  instruction PC
- alloc_tag  output  TAG_W  tag assigned on handshake (= tail index)
- wb_valid  input  1  writeback strobe
- wb_tag  input  TAG_W  entry being completed
- wb_data  input  DATA_W  result
- wb_exc  input  1  instruction raised an exception
- rb_valid  input  1  rollback request (mispredict)
- rb_tag  input  TAG_W  last surviving entry; all younger entries squashed
- cm_valid  output  1  head entry complete, offered for commit
- cm_ready  input  1  commit accepted
- cm_tag, cm_has_dest, cm_areg, cm_data, cm_pc, cm_exc  output  TAG_W/1/AREG_W/DATA_W/PC_W/1  head entry fields
- exc_flush  output  1  one-cycle pulse after an excepting entry commits
- exc_pc  output  PC_W  PC of that entry, held until next exception
- count  output  TAG_W+1  live entries
- empty  output  1  count == 0

## Operation
- Circular buffer; head and tail pointers of TAG_W+1 bits, with the MSB as the wrap bit. count = tail − head, modulo 2^(TAG_W+1). Full when count == DEPTH.
- Each entry holds valid, done, exc, has_dest, areg, pc, and data.
- alloc_ready = !full && !rb_valid && !exc_flush. On handshake: write the entry at tail[TAG_W−1:0] with valid=1 and done=0, then tail+1.
- Writeback: if the entry at wb_tag is valid, set done=1 and write data and exc. A writeback to an invalid entry is ignored, with no error.
- cm_valid = valid[head] && done[head]. Fields are driven combinationally from the head entry. On cm_valid && cm_ready: clear valid[head] and advance head by 1.
- Committing an entry with cm_exc=1:
  - Clear all valid bits.
  - Set tail = head + 1, so the buffer becomes empty.
  - The next cycle, drive exc_flush=1 with exc_pc set to that entry's pc.
- Rollback: on rb_valid, clear valid on every entry strictly younger than rb_tag, and set tail to the pointer of rb_tag + 1, keeping the wrap bit consistent. rb_tag must name a live entry; a rollback to a non-live tag is undefined.
- Priority, highest first: exception commit, rollback, alloc. In the same cycle, a writeback to an entry that is being squashed is dropped. A commit in the same cycle as a rollback is honoured; head advances normally.

## Timing
- Reset (rst_n low, asynchronous): head=tail=0, all valid=0, alloc_ready=1 once released, alloc_tag=0, cm_valid=0, count=0, empty=1, exc_flush=0, exc_pc=0. Reset mid-operation discards every entry immediately.
- alloc_tag is valid combinationally in the handshake cycle.
- A writeback is accepted from the cycle after allocation.
- Writeback-to-commit latency is 1 cycle: done is registered and there is no bypass. The minimum pipeline is alloc at cycle N, wb at N+1, cm_valid at N+2.
- Throughput: 1 alloc, 1 wb, and 1 commit per cycle, all concurrent.
- At full, simultaneous commit and alloc: alloc_ready is still 0 that cycle because it depends on registered count. The slot freed by the commit is usable the next cycle.
- Wrap-around: tags repeat modulo DEPTH, and the wrap bit alone distinguishes full from empty.
- exc_flush is high for exactly one cycle; alloc_ready=0 during that cycle.

## Test plan
- Fill and drain: allocate 16 entries (DEPTH=16), then write them back in reverse order, holding cm_ready=1. Required: alloc_ready=0 after the 16th alloc; commits occur in order with tags 0..15, one per cycle; empty=1 at the end.
- Back-to-back streaming: alloc every cycle and write back each tag one cycle after alloc. Required: steady-state commit every cycle, count stable at 2, tags wrapping 15→0 cleanly across ≥ 40 instructions.
- Rollback: allocate tags 0–7 and complete 0–2, then rb_valid with rb_tag=3. Required: count=4 next cycle; the next alloc_tag is 4; a later writeback to old tag 6 is ignored.
- Exception: 6 entries live; tag 1 is written back with wb_exc=1 and pc=0x100; entry 0 is complete. Required: commit tag 0, then commit tag 1 with cm_exc=1; the next cycle, exc_flush=1, exc_pc=0x100, count=0, alloc_ready=0; alloc_ready=1 one cycle later.
- Commit stall and reset: head complete with cm_ready=0 for 5 cycles. Required: cm_valid stays high and fields are stable. Then assert rst_n=0 mid-stream. Required: cm_valid=0 and count=0 immediately, without waiting for clk.
